// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: bring-up and supervision controller for the on-chip PLL.
//   Holds the PLL in reset for RST_CYCLES cycles. It then waits for a lock that
//   stays high for STABLE_CYCLES consecutive cycles and enables the downstream
//   counters. Loss of lock in RUN and lock timeouts are failures. Each failure
//   retries from RESET until MAX_RETRIES is exhausted; the next failure latches
//   FAULT.
//
// Optional feature macro: PLL_CTRL_HEARTBEAT_EN
//   When defined, hb_led toggles every HB_DIV cycles in RUN and is 1 in FAULT.
//   When undefined, hb_led is tied to 0 and no divider is built.
//
// Ports
//   clk        in   reference clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin bring-up (IDLE only)
//   stop       in   return to IDLE from any non-FAULT state (highest priority)
//   fault_clr  in   leave FAULT -> IDLE
//   pll_locked in   PLL lock, asynchronous, 2-flop synchronised here
//   pll_rst    out  PLL reset, active-high (IDLE, RESET, FAULT)
//   run_en     out  downstream counter enable (RUN)
//   busy       out  RESET / WAIT_LOCK / STABLE
//   fault      out  FAULT
//   retry_cnt  out  failures consumed in the current bring-up
//   state_dbg  out  IDLE=0 RESET=1 WAIT_LOCK=2 STABLE=3 RUN=4 FAULT=5
//   hb_led     out  heartbeat LED
module pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1_000_000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned HB_DIV        = 25_000_000,
    localparam int unsigned RETRY_W      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               fault_clr,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               run_en,
    output logic               busy,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_dbg,
    output logic               hb_led
);

    localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [31:0]        TMO_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    // Elaboration-time parameter sanity checks.
    generate
        if (RST_CYCLES < 1) begin : g_bad_rst
            $error("pll_lock_ctrl: RST_CYCLES must be >= 1");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stab
            $error("pll_lock_ctrl: STABLE_CYCLES must be >= 1");
        end
        if (LOCK_TIMEOUT < 1) begin : g_bad_tmo
            $error("pll_lock_ctrl: LOCK_TIMEOUT must be >= 1");
        end
        if (HB_DIV < 1) begin : g_bad_hb
            $error("pll_lock_ctrl: HB_DIV must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t              state_q,    state_d;
    logic                sync1_q,    sync2_q;
    logic [RST_W-1:0]    rst_cnt_q,  rst_cnt_d;
    logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [31:0]         tmo_cnt_q,  tmo_cnt_d;
    logic [RETRY_W-1:0]  retry_q,    retry_d;
    logic                lk;
    logic                fail;

    assign lk = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            rst_cnt_q  <= '0;
            stab_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= pll_locked;
            sync2_q    <= sync1_q;
            rst_cnt_q  <= rst_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retry_q    <= retry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        stab_cnt_d = stab_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        retry_d    = retry_q;
        fail       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                    retry_d   = '0;
                end
            end
            ST_RESET: begin
                // Timeout window opens when RESET is left, so hold it at zero here.
                tmo_cnt_d = '0;
                if (rst_cnt_q >= RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (tmo_cnt_q >= TMO_LAST) begin
                    fail = 1'b1;
                end else if (lk) begin
                    state_d    = ST_STABLE;
                    stab_cnt_d = '0;
                end
            end
            ST_STABLE: begin
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (tmo_cnt_q >= TMO_LAST) begin
                    fail = 1'b1;
                end else if (!lk) begin
                    // A glitch only restarts the lock qualification.
                    state_d = ST_WAIT_LOCK;
                end else if (stab_cnt_q >= STAB_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lk) fail = 1'b1;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAULT;
            end else begin
                state_d   = ST_RESET;
                rst_cnt_d = '0;
                retry_d   = retry_q + 1'b1;
            end
        end

        // stop overrides every other event except a latched fault.
        if (stop && (state_q != ST_FAULT)) begin
            state_d = ST_IDLE;
        end
    end

    assign pll_rst   = (state_q == ST_IDLE) || (state_q == ST_RESET) || (state_q == ST_FAULT);
    assign run_en    = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    assign fault     = (state_q == ST_FAULT);
    assign retry_cnt = retry_q;
    assign state_dbg = state_q;

`ifdef PLL_CTRL_HEARTBEAT_EN
    localparam logic [31:0] HB_LAST = 32'(HB_DIV - 1);

    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic        hb_q,     hb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    // Divider is held at zero outside RUN so it restarts cleanly on RUN entry.
    always_comb begin
        hb_cnt_d = '0;
        hb_d     = 1'b0;
        if (state_q == ST_RUN) begin
            hb_d = hb_q;
            if (hb_cnt_q >= HB_LAST) begin
                hb_d = ~hb_q;
            end else begin
                hb_cnt_d = hb_cnt_q + 32'd1;
            end
        end
    end

    assign hb_led = (state_q == ST_FAULT) ? 1'b1 : ((state_q == ST_RUN) ? hb_q : 1'b0);
`else
    assign hb_led = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed bench for pll_lock_ctrl.
// DUT parameters: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=50,
// MAX_RETRIES=2, HB_DIV=5.
// Inputs are driven 1 time unit after posedge, and outputs are sampled there too.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, fault_clr, pll_locked;
    logic       pll_rst, run_en, busy, fault, hb_led;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    pll_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (50),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .HB_DIV        (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .fault_clr  (fault_clr),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .run_en     (run_en),
        .busy       (busy),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_dbg  (state_dbg),
        .hb_led     (hb_led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps until state_dbg equals s or the limit is exceeded; the caller judges n.
    task automatic wait_for_state(input logic [2:0] s, input int limit, output int n);
        n = 0;
        while (state_dbg !== s && n <= limit) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fault_clr = 1'b0; pll_locked = 1'b0;
        #12;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en: got %b want 0", run_en); end
        checks++; if (busy !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_busy_fault: got %b%b want 00", busy, fault); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        checks++; if (hb_led !== 1'b0) begin errors++; $display("FAIL reset_hb: got %b want 0", hb_led); end
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL idle_no_start: got %0d want 0", state_dbg); end
    endtask

    task automatic test_nominal;
        int n;
        int rst_len;
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (state_dbg !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL start_latency: got state %0d busy %b want 1 1", state_dbg, busy); end
        rst_len = 0; n = 0;
        while (state_dbg === 3'd1 && n < 20) begin
            if (pll_rst === 1'b1) rst_len++;
            step(1); n++;
        end
        checks++; if (rst_len !== 4) begin errors++; $display("FAIL nominal_rst_len: got %0d want 4", rst_len); end
        checks++; if (state_dbg !== 3'd2 || pll_rst !== 1'b0) begin errors++; $display("FAIL nominal_wait_lock: got state %0d pll_rst %b want 2 0", state_dbg, pll_rst); end
        step(10);
        pll_locked = 1'b1;
        n = 0;
        while (run_en !== 1'b1 && n < 30) begin step(1); n++; end
        checks++; if (n !== 11) begin errors++; $display("FAIL nominal_lock_to_run: got %0d want 11 cycles", n); end
        checks++; if (state_dbg !== 3'd4 || busy !== 1'b0 || pll_rst !== 1'b0) begin errors++; $display("FAIL nominal_run: got state %0d busy %b pll_rst %b want 4 0 0", state_dbg, busy, pll_rst); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL nominal_retry: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_glitch;
        int n;
        pll_locked = 1'b0; stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (state_dbg !== 3'd0 || run_en !== 1'b0) begin errors++; $display("FAIL stop_from_run: got state %0d run_en %b want 0 0", state_dbg, run_en); end
        start = 1'b1; step(1); start = 1'b0;
        wait_for_state(3'd2, 20, n);
        checks++; if (n > 20) begin errors++; $display("FAIL glitch_reach_wait: got %0d cycles want <=20", n); end
        pll_locked = 1'b1;
        wait_for_state(3'd3, 10, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL glitch_reach_stable: got %0d cycles want 3", n); end
        step(4);
        pll_locked = 1'b0; step(1); pll_locked = 1'b1;
        step(1);
        checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL glitch_still_stable: got %0d want 3", state_dbg); end
        step(1);
        checks++; if (state_dbg !== 3'd2 || run_en !== 1'b0) begin errors++; $display("FAIL glitch_to_wait: got state %0d run_en %b want 2 0", state_dbg, run_en); end
        step(1);
        checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL glitch_relock: got %0d want 3", state_dbg); end
        n = 0;
        while (run_en !== 1'b1 && n < 30) begin step(1); n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL glitch_stable_restart: got %0d want 8 cycles", n); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL glitch_retry: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_timeout;
        int n;
        int pulses;
        int rst_len;
        int wl_len;
        logic [2:0] prev;
        logic [2:0] cur;
        pll_locked = 1'b0; stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL timeout_idle: got %0d want 0", state_dbg); end
        start = 1'b1; step(1); start = 1'b0;
        prev = 3'd0; pulses = 0; rst_len = 0; wl_len = 0; n = 0;
        while (1) begin
            cur = state_dbg;
            if (prev == 3'd1 && cur != 3'd1) begin
                checks++; if (rst_len !== 4) begin errors++; $display("FAIL timeout_rst_len: got %0d want 4", rst_len); end
            end
            if (prev == 3'd2 && cur != 3'd2) begin
                checks++; if (wl_len !== 50) begin errors++; $display("FAIL timeout_window: got %0d want 50", wl_len); end
            end
            if (cur == 3'd1 && prev != 3'd1) begin
                checks++; if (retry_cnt !== 2'(pulses)) begin errors++; $display("FAIL timeout_retry_step: got %0d want %0d", retry_cnt, pulses); end
                pulses++; rst_len = 0;
            end
            if (cur == 3'd2 && prev != 3'd2) wl_len = 0;
            if (cur == 3'd1) rst_len++;
            if (cur == 3'd2) wl_len++;
            prev = cur;
            if (fault === 1'b1 || n >= 400) break;
            step(1); n++;
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL timeout_pulses: got %0d want 3", pulses); end
        checks++; if (fault !== 1'b1 || state_dbg !== 3'd5) begin errors++; $display("FAIL timeout_fault: got fault %b state %0d want 1 5", fault, state_dbg); end
        checks++; if (retry_cnt !== 2'd2 || pll_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fault_outputs: got retry %0d pll_rst %b busy %b want 2 1 0", retry_cnt, pll_rst, busy); end
`ifdef PLL_CTRL_HEARTBEAT_EN
        checks++; if (hb_led !== 1'b1) begin errors++; $display("FAIL fault_hb: got %b want 1", hb_led); end
`else
        checks++; if (hb_led !== 1'b0) begin errors++; $display("FAIL fault_hb: got %b want 0", hb_led); end
`endif
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        checks++; if (state_dbg !== 3'd5) begin errors++; $display("FAIL fault_ignores_start_stop: got %0d want 5", state_dbg); end
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        checks++; if (state_dbg !== 3'd0 || retry_cnt !== 2'd0 || fault !== 1'b0) begin errors++; $display("FAIL fault_clr: got state %0d retry %0d fault %b want 0 0 0", state_dbg, retry_cnt, fault); end
    endtask

    task automatic test_run_loss;
        int n;
        pll_locked = 1'b1; start = 1'b1; step(1); start = 1'b0;
        wait_for_state(3'd4, 60, n);
        checks++; if (n > 60) begin errors++; $display("FAIL loss_reach_run: got %0d cycles want <=60", n); end
        pll_locked = 1'b0;
        step(2);
        checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL loss_too_early: got run_en %b want 1", run_en); end
        step(1);
        checks++; if (run_en !== 1'b0 || state_dbg !== 3'd1) begin errors++; $display("FAIL loss_run_en: got run_en %b state %0d want 0 1", run_en, state_dbg); end
        checks++; if (retry_cnt !== 2'd1 || pll_rst !== 1'b1) begin errors++; $display("FAIL loss_retry: got retry %0d pll_rst %b want 1 1", retry_cnt, pll_rst); end
        pll_locked = 1'b1;
        wait_for_state(3'd4, 60, n);
        checks++; if (n > 60 || run_en !== 1'b1) begin errors++; $display("FAIL loss_relock: got %0d cycles run_en %b want <=60 1", n, run_en); end
        checks++; if (retry_cnt !== 2'd1) begin errors++; $display("FAIL loss_relock_retry: got %0d want 1", retry_cnt); end
    endtask

    task automatic test_heartbeat;
        int n;
        stop = 1'b1; step(1); stop = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        wait_for_state(3'd4, 60, n);
        checks++; if (n > 60) begin errors++; $display("FAIL hb_reach_run: got %0d cycles want <=60", n); end
`ifdef PLL_CTRL_HEARTBEAT_EN
        checks++; if (hb_led !== 1'b0) begin errors++; $display("FAIL hb_entry: got %b want 0", hb_led); end
        step(4);
        checks++; if (hb_led !== 1'b0) begin errors++; $display("FAIL hb_before_toggle: got %b want 0", hb_led); end
        step(1);
        checks++; if (hb_led !== 1'b1) begin errors++; $display("FAIL hb_first_toggle: got %b want 1", hb_led); end
        step(4);
        checks++; if (hb_led !== 1'b1) begin errors++; $display("FAIL hb_high_phase: got %b want 1", hb_led); end
        step(1);
        checks++; if (hb_led !== 1'b0) begin errors++; $display("FAIL hb_second_toggle: got %b want 0", hb_led); end
`else
        for (int i = 0; i < 12; i++) begin
            step(1);
            checks++; if (hb_led !== 1'b0) begin errors++; $display("FAIL hb_tied_low: got %b want 0 at cycle %0d", hb_led, i); end
        end
`endif
    endtask

    task automatic test_priority;
        int n;
        stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (state_dbg !== 3'd0 || run_en !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL prio_stop_run: got state %0d run_en %b pll_rst %b want 0 0 1", state_dbg, run_en, pll_rst); end
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL prio_start_stop: got %0d want 0", state_dbg); end
        step(1);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL prio_stays_idle: got %0d want 0", state_dbg); end
        pll_locked = 1'b0; start = 1'b1; step(1); start = 1'b0;
        wait_for_state(3'd2, 20, n);
        checks++; if (n > 20) begin errors++; $display("FAIL prio_reach_wait: got %0d cycles want <=20", n); end
        stop = 1'b1; step(1); stop = 1'b0;
        checks++; if (state_dbg !== 3'd0 || pll_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL prio_stop_wait: got state %0d pll_rst %b busy %b want 0 1 0", state_dbg, pll_rst, busy); end
        pll_locked = 1'b1; start = 1'b1; step(1); start = 1'b0;
        wait_for_state(3'd4, 60, n);
        checks++; if (n > 60) begin errors++; $display("FAIL async_reach_run: got %0d cycles want <=60", n); end
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (run_en !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL async_reset_outputs: got run_en %b pll_rst %b want 0 1", run_en, pll_rst); end
        checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_state: got state %0d busy %b want 0 0", state_dbg, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL after_async_reset: got %0d want 0", state_dbg); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_run_loss();
        test_heartbeat();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
